pfw_learn: RTL and testbench



---
 rtl/pfw_learn.sv | 205 ++++++++++++++++++++
 tb/tb_pfw_learn.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pfw_learn.sv
// pfw_learn: parametrised packet forwarder with a small SMAC learning table.
// Decides per packet on the head beat, emits an action word with the
// head output beat and passes every beat through one cycle later.
module pfw_learn #(
    parameter int PORT_NUM  = 4,
    parameter int CPU_PORT  = 3,
    parameter int TBL_DEPTH = 8,
    parameter int PTR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [133:0]          in_pfw_data,
    input  logic                  in_pfw_data_wr,
    input  logic [2:0]            in_pfw_pkttype,
    input  logic [101:0]          in_pfw_key,
    output logic [133:0]          out_pfw_data,
    output logic                  out_pfw_data_wr,
    output logic                  out_pfw_valid,
    output logic                  out_pfw_valid_wr,
    output logic [PORT_NUM+4:0]   out_pfw_action,
    output logic                  out_pfw_action_wr,
    input  logic [47:0]           local_mac_addr,
    input  logic [PORT_NUM-1:0]   port_en,
    input  logic                  tbl_clr,
    output logic [31:0]           drop_cnt
);
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
    localparam logic [1:0] M_UNI = 2'b00, M_FLOOD = 2'b01, M_BCAST = 2'b10;

    state_t              state_q, state_d;
    logic [133:0]        data_q, data_d;
    logic                data_wr_q, data_wr_d, valid_wr_q, valid_wr_d, action_wr_q, action_wr_d;
    logic [PORT_NUM+4:0] action_q, action_d;
    logic [31:0]         drop_cnt_q, drop_cnt_d;

    // learning table: valid bits and pointer are reset, payload is not
    logic [TBL_DEPTH-1:0] vld_q;
    logic [47:0]          mac_q  [TBL_DEPTH];
    logic [2:0]           port_q [TBL_DEPTH];
    logic [PTR_W-1:0]     ptr_q;

    logic                is_head, is_tail;
    logic [47:0]         dmac, smac;
    logic [5:0]          inport;
    logic [7:0]          smid;
    logic                src_port, smac_local, inport_ok;
    logic                dhit, shit;
    logic [2:0]          dport;
    logic [PTR_W-1:0]    sidx;
    logic [1:0]          mode;
    logic [PORT_NUM-1:0] bmp, excl, bmp_fin;
    logic                drop, learn;

    function automatic logic [PORT_NUM-1:0] onehot(input logic [5:0] p);
        logic [PORT_NUM-1:0] r;
        for (int i = 0; i < PORT_NUM; i++) r[i] = (p == 6'(i));
        return r;
    endfunction

    assign is_head    = in_pfw_data_wr && (in_pfw_data[133:132] == 2'b01);
    assign is_tail    = in_pfw_data_wr && (in_pfw_data[133:132] == 2'b10);
    assign dmac       = in_pfw_key[101:54];
    assign smac       = in_pfw_key[53:6];
    assign inport     = in_pfw_key[5:0];
    assign smid       = in_pfw_data[95:88];
    assign src_port   = (smid != 8'd4) && (smid != 8'd128);
    assign smac_local = (smac == local_mac_addr);
    assign inport_ok  = (inport < 6'(PORT_NUM));

    // table search: DMAC for forwarding, SMAC for in-place relearn
    always_comb begin
        dhit  = 1'b0;
        dport = '0;
        shit  = 1'b0;
        sidx  = '0;
        for (int i = 0; i < TBL_DEPTH; i++) begin
            if (vld_q[i] && mac_q[i] == dmac && !dhit) begin
                dhit  = 1'b1;
                dport = port_q[i];
            end
            if (vld_q[i] && mac_q[i] == smac && !shit) begin
                shit = 1'b1;
                sidx = PTR_W'(i);
            end
        end
    end

    // forwarding decision for the head beat presented this cycle
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) excl[i] = port_en[i] && (inport != 6'(i));
        mode = M_UNI;
        bmp  = '0;
        drop = 1'b0;
        if (!src_port) begin
            if (inport_ok) bmp = onehot(inport);
            else begin
                mode = M_BCAST;
                bmp  = port_en;
            end
        end else if (smac_local) begin
            drop = 1'b1;
        end else if (&dmac) begin
            mode = M_BCAST;
            bmp  = excl;
        end else if (dmac == local_mac_addr) begin
            bmp = onehot(6'(CPU_PORT));
        end else if (dhit) begin
            bmp = onehot({3'b000, dport});
        end else begin
            mode = M_FLOOD;
            bmp  = excl;
        end
        bmp_fin = bmp & port_en;
        if (bmp_fin == '0) drop = 1'b1;
        learn = is_head && src_port && !smac_local && !smac[40] && inport_ok;
    end

    // packet FSM: next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        data_d      = '0;
        data_wr_d   = 1'b0;
        valid_wr_d  = 1'b0;
        action_d    = '0;
        action_wr_d = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        if (is_head) begin
            // a head always restarts, abandoning any unfinished packet
            if (drop) begin
                state_d = DROP;
                if (drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
            end else begin
                state_d     = FWD;
                data_d      = in_pfw_data;
                data_wr_d   = 1'b1;
                action_d    = {mode, in_pfw_pkttype, bmp_fin};
                action_wr_d = 1'b1;
            end
        end else begin
            case (state_q)
                FWD: if (in_pfw_data_wr) begin
                    data_d    = in_pfw_data;
                    data_wr_d = 1'b1;
                    if (is_tail) begin
                        valid_wr_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                DROP: if (is_tail) state_d = IDLE;
                default: ;
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            data_wr_q   <= 1'b0;
            valid_wr_q  <= 1'b0;
            action_q    <= '0;
            action_wr_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            data_wr_q   <= data_wr_d;
            valid_wr_q  <= valid_wr_d;
            action_q    <= action_d;
            action_wr_q <= action_wr_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // table valid bits and replacement pointer; clear wins over learn
    always_ff @(posedge clk) begin
        if (!rst_n || tbl_clr) begin
            vld_q <= '0;
            ptr_q <= '0;
        end else if (learn && !shit) begin
            vld_q[ptr_q] <= 1'b1;
            ptr_q        <= ptr_q + PTR_W'(1);
        end
    end

    // table payload: relearn overwrites port in place, new SMAC takes the pointer slot
    always_ff @(posedge clk) begin
        if (learn && !tbl_clr) begin
            if (shit) port_q[sidx] <= inport[2:0];
            else begin
                mac_q[ptr_q]  <= smac;
                port_q[ptr_q] <= inport[2:0];
            end
        end
    end

    assign out_pfw_data      = data_q;
    assign out_pfw_data_wr   = data_wr_q;
    assign out_pfw_valid     = valid_wr_q;
    assign out_pfw_valid_wr  = valid_wr_q;
    assign out_pfw_action    = action_q;
    assign out_pfw_action_wr = action_wr_q;
    assign drop_cnt          = drop_cnt_q;
endmodule

// File: tb/tb_pfw_learn.sv
// tb_pfw_learn: directed + random stimulus, queue-based reference model,
// scoreboard monitor checking every output beat and its cycle.
module tb_pfw_learn;
    localparam int PN = 4, CPU = 3, DEPTH = 8;
    localparam logic [47:0] LM = 48'h02AA_BBCC_DDEE;
    localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MA = 48'h0200_0000_00A0;
    localparam logic [47:0] MB = 48'h0200_0000_00B0;
    localparam logic [47:0] MC = 48'h0200_0000_00C0;
    localparam logic [47:0] MD = 48'h0200_0000_00D0;
    localparam logic [47:0] ME = 48'h0200_0000_00E0;
    localparam logic [47:0] MX = 48'h0100_0000_0001;   // group address, never learned

    logic         clk = 1'b0, rst_n;
    logic [133:0] in_pfw_data, out_pfw_data;
    logic         in_pfw_data_wr, out_pfw_data_wr, out_pfw_valid, out_pfw_valid_wr, out_pfw_action_wr;
    logic [2:0]   in_pfw_pkttype;
    logic [101:0] in_pfw_key;
    logic [PN+4:0] out_pfw_action;
    logic [47:0]  local_mac_addr;
    logic [PN-1:0] port_en;
    logic         tbl_clr;
    logic [31:0]  drop_cnt;

    pfw_learn #(.PORT_NUM(PN), .CPU_PORT(CPU), .TBL_DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_pfw_data(in_pfw_data), .in_pfw_data_wr(in_pfw_data_wr),
        .in_pfw_pkttype(in_pfw_pkttype), .in_pfw_key(in_pfw_key), .out_pfw_data(out_pfw_data),
        .out_pfw_data_wr(out_pfw_data_wr), .out_pfw_valid(out_pfw_valid),
        .out_pfw_valid_wr(out_pfw_valid_wr), .out_pfw_action(out_pfw_action),
        .out_pfw_action_wr(out_pfw_action_wr), .local_mac_addr(local_mac_addr),
        .port_en(port_en), .tbl_clr(tbl_clr), .drop_cnt(drop_cnt));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [133:0] data;
        logic         aw;
        logic [PN+4:0] act;
        logic         vw;
        int           at;
    } exp_t;
    exp_t expq[$];
    exp_t me;
    int vectors = 0, miscompares = 0;

    // reference model: packet mode, SMAC->port map, insertion order for eviction
    int          m_st = 0;                 // 0 between packets, 1 forwarding, 2 discarding
    logic [2:0]  m_tbl [logic [47:0]];
    logic [47:0] m_order[$];
    logic [31:0] m_dc = 0;

    task automatic model_step(input logic [133:0] d, input logic wr, input logic [101:0] key,
                              input logic [2:0] pt, input logic rst, input logic clr);
        logic [47:0] dmac, smac;
        int inp, smid, pe, excl, bmp, mode;
        bit drop, learn, head, tail;
        exp_t e;
        if (!rst) begin
            m_st = 0; m_tbl.delete(); m_order.delete(); m_dc = 0;
            return;
        end
        head = wr && d[133:132] == 2'b01;
        tail = wr && d[133:132] == 2'b10;
        dmac = key[101:54]; smac = key[53:6]; inp = int'(key[5:0]); smid = int'(d[95:88]);
        pe = int'(port_en);
        e.data = d; e.at = cyc + 1; e.aw = 1'b0; e.vw = 1'b0; e.act = '0;
        if (head) begin
            excl = (inp < PN) ? (pe & ~(1 << inp)) : pe;
            drop = 0; learn = 0; mode = 0; bmp = 0;
            if (smid == 4 || smid == 128) begin
                if (inp < PN) bmp = 1 << inp;
                else begin mode = 2; bmp = pe; end
            end else begin
                learn = (smac != local_mac_addr) && !smac[40] && (inp < PN);
                if (smac == local_mac_addr) drop = 1;
                else if (dmac == BC) begin mode = 2; bmp = excl; end
                else if (dmac == local_mac_addr) bmp = 1 << CPU;
                else if (m_tbl.exists(dmac)) bmp = 1 << m_tbl[dmac];
                else begin mode = 1; bmp = excl; end
            end
            bmp = bmp & pe;
            if (bmp == 0) drop = 1;
            if (drop) begin
                m_st = 2;
                if (m_dc != 32'hFFFF_FFFF) m_dc = m_dc + 1;
            end else begin
                m_st = 1; e.aw = 1'b1; e.act = {mode[1:0], pt, bmp[PN-1:0]};
                expq.push_back(e);
            end
            if (learn && !clr) begin
                if (m_tbl.exists(smac)) m_tbl[smac] = 3'(inp);
                else begin
                    if (m_order.size() == DEPTH) m_tbl.delete(m_order.pop_front());
                    m_order.push_back(smac);
                    m_tbl[smac] = 3'(inp);
                end
            end
        end else if (m_st == 1 && wr) begin
            e.vw = tail;
            expq.push_back(e);
            if (tail) m_st = 0;
        end else if (m_st == 2 && tail) begin
            m_st = 0;
        end
        if (clr) begin m_tbl.delete(); m_order.delete(); end
    endtask

    function automatic logic [133:0] rnd_beat();
        return {2'($urandom_range(3)), 4'($urandom_range(15)), $urandom, $urandom, $urandom, $urandom};
    endfunction

    // one input cycle: check drop_cnt from the previous cycle, then drive and model
    task automatic cycle(input logic [133:0] d, input logic wr, input logic [101:0] key,
                         input logic [2:0] pt, input logic rst, input logic clr);
        @(posedge clk); #1;
        vectors++;
        if (drop_cnt !== m_dc) begin
            miscompares++;
            $display("FAIL drop_cnt cyc=%0d got %0d want %0d", cyc, drop_cnt, m_dc);
        end
        in_pfw_data = d; in_pfw_data_wr = wr; in_pfw_key = key; in_pfw_pkttype = pt;
        rst_n = rst; tbl_clr = clr;
        model_step(d, wr, key, pt, rst, clr);
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) cycle(rnd_beat(), 1'b0, '0, 3'd0, 1'b1, clr);
    endtask

    task automatic pkt(input int inp, input int smid, input logic [47:0] dmac, input logic [47:0] smac,
                       input int nb, input bit tail_en, input int rst_at, input int clr_at, input int gap);
        logic [133:0] d;
        logic [101:0] key;
        logic [2:0]   pt;
        key = {dmac, smac, 6'(inp)};
        pt  = 3'($urandom_range(7));
        for (int i = 0; i < nb; i++) begin
            d = rnd_beat();
            if (i == 0) begin d[133:132] = 2'b01; d[95:88] = 8'(smid); end
            else if (i == nb - 1 && tail_en) d[133:132] = 2'b10;
            else d[133:132] = 2'b11;
            cycle(d, 1'b1, key, pt, !(i == rst_at), i == clr_at);
        end
        for (int i = 0; i < gap; i++) cycle(rnd_beat(), 1'b0, key, pt, 1'b1, 1'b0);
    endtask

    task automatic chk(input string name, input logic [133:0] got, input logic [133:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [47:0] smac_s(input int i);
        return 48'h0210_0000_0000 | 48'(i);
    endfunction

    // scoreboard monitor: every output beat must match the next expected beat and cycle
    always @(negedge clk) begin
        if (out_pfw_data_wr || out_pfw_action_wr || out_pfw_valid_wr || out_pfw_valid) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL beat cyc=%0d unexpected output aw=%b vw=%b data=%h",
                         cyc, out_pfw_action_wr, out_pfw_valid_wr, out_pfw_data);
            end else begin
                me = expq.pop_front();
                if (me.at != cyc || out_pfw_data !== me.data || out_pfw_data_wr !== 1'b1 ||
                    out_pfw_action_wr !== me.aw || out_pfw_valid_wr !== me.vw ||
                    out_pfw_valid !== me.vw || (me.aw && out_pfw_action !== me.act)) begin
                    miscompares++;
                    $display("FAIL beat cyc=%0d got aw=%b act=%h vw=%b v=%b data=%h want cyc=%0d aw=%b act=%h vw=%b data=%h",
                             cyc, out_pfw_action_wr, out_pfw_action, out_pfw_valid_wr, out_pfw_valid,
                             out_pfw_data, me.at, me.aw, me.act, me.vw, me.data);
                end
            end
        end
    end

    initial begin
        logic [47:0] pool [14];
        int inp, smid, nb, r;
        logic [47:0] dm, sm;
        rst_n = 1'b0; tbl_clr = 1'b0; in_pfw_data = '0; in_pfw_data_wr = 1'b0;
        in_pfw_key = '0; in_pfw_pkttype = '0; port_en = 4'hF; local_mac_addr = LM;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_wr",   134'(out_pfw_data_wr),   '0);
        chk("rst_action_wr", 134'(out_pfw_action_wr), '0);
        chk("rst_valid_wr",  134'(out_pfw_valid_wr),  '0);
        chk("rst_valid",     134'(out_pfw_valid),     '0);
        chk("rst_action",    134'(out_pfw_action),    '0);
        chk("rst_data",      out_pfw_data,            '0);
        chk("rst_drop_cnt",  134'(drop_cnt),          '0);
        idle(2, 1'b0);

        // learning then unicast back to the learned port
        pkt(0, 0, MB, MA, 3, 1, -1, -1, 0);
        pkt(1, 0, MA, MC, 3, 1, -1, -1, 1);
        // broadcast with a masked port
        port_en = 4'b1011;
        pkt(2, 0, BC, MD, 3, 1, -1, -1, 1);
        port_en = 4'hF;
        // drops: own SMAC, and unicast to a disabled learned port
        pkt(1, 0, MB, LM, 3, 1, -1, -1, 1);
        pkt(3, 0, MB, ME, 2, 1, -1, -1, 0);
        port_en = 4'b0111;
        pkt(0, 0, ME, MX, 3, 1, -1, -1, 1);
        port_en = 4'hF;
        pkt(2, 0, LM, MX, 2, 1, -1, -1, 0);        // to the CPU port
        // LCM / PTP sourced
        pkt(2, 128, MB, MB, 3, 1, -1, -1, 0);
        pkt(9, 4, MB, MB, 3, 1, -1, -1, 0);
        pkt(0, 0, MB, MX, 2, 1, -1, -1, 0);        // MB must still miss

        // table wrap, relearn, clear
        idle(1, 1'b1);
        for (int i = 0; i < 9; i++) pkt(i % PN, 0, MB, smac_s(i), 2, 1, -1, -1, 0);
        pkt(1, 0, smac_s(0), MX, 2, 1, -1, -1, 0);
        pkt(1, 0, smac_s(8), MX, 2, 1, -1, -1, 0);
        pkt(0, 0, MB, smac_s(3), 2, 1, -1, -1, 0);  // port 3 -> 0
        pkt(1, 0, MB, smac_s(9), 2, 1, -1, -1, 0);  // evicts smac_s(1)
        pkt(2, 0, smac_s(1), MX, 2, 1, -1, -1, 0);
        pkt(2, 0, smac_s(3), MX, 2, 1, -1, -1, 0);
        pkt(1, 0, smac_s(2), MX, 2, 1, -1, -1, 0);
        idle(1, 1'b1);
        pkt(2, 0, smac_s(3), MX, 2, 1, -1, -1, 0);
        pkt(2, 0, MB, smac_s(10), 2, 1, -1, 0, 0);  // clear in the same cycle as learn
        pkt(1, 0, smac_s(10), MX, 2, 1, -1, -1, 0);

        // stress: zero-gap, abandoned packet, reset mid-packet
        for (int i = 0; i < 4; i++) pkt(i, 0, BC, smac_s(20 + i), 3, 1, -1, -1, 0);
        pkt(1, 0, smac_s(20), MX, 3, 0, -1, -1, 0);
        pkt(2, 0, smac_s(21), MX, 3, 1, -1, -1, 0);
        pkt(3, 0, BC, MX, 3, 1, 1, -1, 0);
        pkt(0, 0, smac_s(22), MX, 3, 1, -1, -1, 0);

        // randomized traffic over a small MAC pool so hits, misses and evictions all occur
        for (int i = 0; i < 12; i++) pool[i] = {8'h02, 32'h0, 8'(i)};
        pool[12] = LM; pool[13] = BC;
        for (int n = 0; n < 400; n++) begin
            if (n % 20 == 0) port_en = 4'($urandom_range(15));
            inp  = ($urandom_range(9) == 0) ? 4 + int'($urandom_range(5)) : int'($urandom_range(3));
            r    = int'($urandom_range(9));
            smid = (r == 0) ? 4 : (r == 1) ? 128 : int'($urandom_range(3));
            dm   = pool[$urandom_range(13)];
            sm   = ($urandom_range(9) == 0) ? MX : pool[$urandom_range(12)];
            nb   = 2 + int'($urandom_range(3));
            pkt(inp, smid, dm, sm, nb, $urandom_range(19) != 0,
                ($urandom_range(99) == 0) ? int'($urandom_range(nb - 1)) : -1,
                ($urandom_range(29) == 0) ? int'($urandom_range(nb - 1)) : -1,
                int'($urandom_range(2)));
        end

        idle(4, 1'b0);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL pending got %0d beats never output want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
